// File: rtl/lsu_axi_bridge_if.sv
// Handshake bundles for the LSU bridge: pipeline request/response side and
// the data-memory bus side. Signal names follow the block's port list.
interface lsu_req_if #(parameter int XLEN = 64, parameter int ADDR_W = 64);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [XLEN-1:0]   req_wdata;
  logic [1:0]        req_size;
  logic              req_sext;
  logic              resp_valid;
  logic [XLEN-1:0]   resp_rdata;
  logic              resp_err;
  logic              busy;

  modport master (output req_valid, req_we, req_addr, req_wdata, req_size, req_sext,
                  input  req_ready, resp_valid, resp_rdata, resp_err, busy);
  modport slave  (input  req_valid, req_we, req_addr, req_wdata, req_size, req_sext,
                  output req_ready, resp_valid, resp_rdata, resp_err, busy);
endinterface

interface lsu_mem_if #(parameter int XLEN = 64, parameter int ADDR_W = 64);
  logic              w_valid_i;
  logic              w_ready_o;
  logic [ADDR_W-1:0] w_addr_i;
  logic [XLEN-1:0]   w_data_i;
  logic [XLEN/8-1:0] w_mask_i;
  logic              w_valid_o;
  logic              w_ready_i;
  logic              rx_r_valid_i;
  logic              rx_r_ready_o;
  logic [ADDR_W-1:0] rx_r_addr_i;
  logic [7:0]        rx_r_size_i;
  logic [XLEN-1:0]   rx_data_read_o;
  logic              rx_data_valid;
  logic              rx_data_ready;

  modport master (output w_valid_i, w_addr_i, w_data_i, w_mask_i, w_ready_i,
                         rx_r_valid_i, rx_r_addr_i, rx_r_size_i, rx_data_ready,
                  input  w_ready_o, w_valid_o, rx_r_ready_o, rx_data_read_o, rx_data_valid);
  modport slave  (input  w_valid_i, w_addr_i, w_data_i, w_mask_i, w_ready_i,
                         rx_r_valid_i, rx_r_addr_i, rx_r_size_i, rx_data_ready,
                  output w_ready_o, w_valid_o, rx_r_ready_o, rx_data_read_o, rx_data_valid);
endinterface

// File: rtl/lsu_axi_bridge.sv
// Single-outstanding load/store unit bridging the MEM stage to the data bus.
// Define LSU_MISALIGN_SPLIT_EN to split misaligned accesses into two beats.
module lsu_axi_bridge #(
  parameter int XLEN   = 64,
  parameter int ADDR_W = 64
) (
  input  logic     clk,
  input  logic     rst,
  lsu_req_if.slave req,
  lsu_mem_if.master mem
);
  localparam int BYTES = XLEN / 8;
  localparam int OFF_W = $clog2(BYTES);
`ifdef LSU_MISALIGN_SPLIT_EN
  localparam bit SPLIT = 1'b1;
`else
  localparam bit SPLIT = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, WREQ, WRESP, RREQ, RDATA, RESP} state_t;
  state_t state;

  logic               accept;
  logic [OFF_W-1:0]   off_in, off_q;
  logic [3:0]         n_in, n_q;
  logic [BYTES-1:0]   nmask;
  logic [2*BYTES-1:0] mask2;
  logic [2*XLEN-1:0]  data2;
  logic               illegal, misal;
  logic [ADDR_W-1:0]  base_in, base_q;
  logic [1:0]         size_q;
  logic               sext_q, split_q, second_q;
  logic [BYTES-1:0]   mask_hi_q;
  logic [XLEN-1:0]    data_hi_q, beat_lo, raw, ext;
  logic [2*XLEN-1:0]  cat;
  logic               sgn;

  assign accept   = req.req_valid && req.req_ready;
  assign req.busy = (state != IDLE) || accept;

  // Request decode: the doubled-width mask/data hold both beats of a split.
  assign off_in  = req.req_addr[OFF_W-1:0];
  assign n_in    = 4'd1 << req.req_size;
  assign base_in = {req.req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  assign illegal = 5'(n_in) > 5'(BYTES);
  assign misal   = (5'(off_in) + 5'(n_in)) > 5'(BYTES);
  assign mask2   = {{BYTES{1'b0}}, nmask} << off_in;
  assign data2   = {{XLEN{1'b0}}, req.req_wdata} << {off_in, 3'b000};

  always_comb begin
    nmask = '0;
    for (int i = 0; i < BYTES; i++) nmask[i] = 4'(i) < n_in;
  end

  // Load extraction: second beat sits above the first before shifting down.
  assign n_q = 4'd1 << size_q;
  assign cat = second_q ? {mem.rx_data_read_o, beat_lo} : {{XLEN{1'b0}}, mem.rx_data_read_o};
  assign raw = XLEN'(cat >> {off_q, 3'b000});

  always_comb begin
    sgn = 1'b0;
    ext = '0;
    for (int i = 0; i < BYTES; i++)
      if (4'(i + 1) == n_q) sgn = sext_q & raw[8*i+7];
    for (int i = 0; i < BYTES; i++)
      ext[8*i +: 8] = (4'(i) < n_q) ? raw[8*i +: 8] : {8{sgn}};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state             <= IDLE;
      req.req_ready     <= 1'b1;
      req.resp_valid    <= 1'b0;
      req.resp_err      <= 1'b0;
      req.resp_rdata    <= '0;
      mem.w_valid_i     <= 1'b0;
      mem.w_addr_i      <= '0;
      mem.w_data_i      <= '0;
      mem.w_mask_i      <= '0;
      mem.w_ready_i     <= 1'b0;
      mem.rx_r_valid_i  <= 1'b0;
      mem.rx_r_addr_i   <= '0;
      mem.rx_r_size_i   <= '0;
      mem.rx_data_ready <= 1'b0;
      off_q     <= '0;
      size_q    <= '0;
      sext_q    <= 1'b0;
      split_q   <= 1'b0;
      second_q  <= 1'b0;
      base_q    <= '0;
      mask_hi_q <= '0;
      data_hi_q <= '0;
      beat_lo   <= '0;
    end else begin
      req.resp_valid <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          req.req_ready <= 1'b0;
          off_q     <= off_in;
          size_q    <= req.req_size;
          sext_q    <= req.req_sext;
          split_q   <= misal;
          second_q  <= 1'b0;
          base_q    <= base_in;
          mask_hi_q <= mask2[2*BYTES-1:BYTES];
          data_hi_q <= data2[2*XLEN-1:XLEN];
          if (illegal || (misal && !SPLIT)) begin
            state          <= RESP;
            req.resp_valid <= 1'b1;
            req.resp_err   <= 1'b1;
            req.resp_rdata <= '0;
          end else if (req.req_we) begin
            state         <= WREQ;
            mem.w_valid_i <= 1'b1;
            mem.w_addr_i  <= base_in;
            mem.w_data_i  <= data2[XLEN-1:0];
            mem.w_mask_i  <= mask2[BYTES-1:0];
          end else begin
            state            <= RREQ;
            mem.rx_r_valid_i <= 1'b1;
            mem.rx_r_addr_i  <= base_in;
            mem.rx_r_size_i  <= 8'(OFF_W);
          end
        end
        WREQ: if (mem.w_ready_o) begin
          mem.w_valid_i <= 1'b0;
          mem.w_ready_i <= 1'b1;
          state         <= WRESP;
        end
        WRESP: if (mem.w_valid_o) begin
          mem.w_ready_i <= 1'b0;
          if (split_q && !second_q) begin
            second_q      <= 1'b1;
            state         <= WREQ;
            mem.w_valid_i <= 1'b1;
            mem.w_addr_i  <= base_q + ADDR_W'(BYTES);
            mem.w_data_i  <= data_hi_q;
            mem.w_mask_i  <= mask_hi_q;
          end else begin
            state          <= RESP;
            req.resp_valid <= 1'b1;
            req.resp_err   <= 1'b0;
            req.resp_rdata <= '0;
          end
        end
        RREQ: if (mem.rx_r_ready_o) begin
          mem.rx_r_valid_i  <= 1'b0;
          mem.rx_data_ready <= 1'b1;
          state             <= RDATA;
        end
        RDATA: if (mem.rx_data_valid) begin
          mem.rx_data_ready <= 1'b0;
          if (split_q && !second_q) begin
            beat_lo          <= mem.rx_data_read_o;
            second_q         <= 1'b1;
            state            <= RREQ;
            mem.rx_r_valid_i <= 1'b1;
            mem.rx_r_addr_i  <= base_q + ADDR_W'(BYTES);
          end else begin
            state          <= RESP;
            req.resp_valid <= 1'b1;
            req.resp_err   <= 1'b0;
            req.resp_rdata <= ext;
          end
        end
        RESP: begin
          state         <= IDLE;
          req.req_ready <= 1'b1;
        end
        default: begin
          state         <= IDLE;
          req.req_ready <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_lsu_axi_bridge.sv
// Directed bench for lsu_axi_bridge: vector table on a 64-bit instance with a
// configurable-latency bus responder, plus stall, reset and 32-bit sequences.
module tb_lsu_axi_bridge;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lsu_req_if #(.XLEN(64), .ADDR_W(64)) r64();
  lsu_mem_if #(.XLEN(64), .ADDR_W(64)) m64();
  lsu_req_if #(.XLEN(32), .ADDR_W(32)) r32();
  lsu_mem_if #(.XLEN(32), .ADDR_W(32)) m32();

  lsu_axi_bridge #(.XLEN(64), .ADDR_W(64)) dut64 (.clk(clk), .rst(rst), .req(r64), .mem(m64));
  lsu_axi_bridge #(.XLEN(32), .ADDR_W(32)) dut32 (.clk(clk), .rst(rst), .req(r32), .mem(m32));

  typedef struct {
    logic        we;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [1:0]  size;
    logic        sext;
    logic [63:0] b0, b1;
    logic [63:0] rdata;
    logic        err;
    int          nbus;
    int          lat;
    logic [63:0] a0;
    logic [7:0]  m0;
    logic [63:0] d0;
    logic [63:0] a1;
    logic [7:0]  m1;
    logic [63:0] d1;
  } vec_t;

  int errors = 0;
  int checks = 0;

  // responder configuration (written by main) and observations (written by responder)
  int wreq_dly = 0, wresp_dly = 0, rreq_dly = 0, rdat_dly = 0;
  logic [63:0] beat0 = '0, beat1 = '0;
  int beat_base = 0;
  int resp_cnt = 0, busy_viol = 0, hs_viol = 0, ndata = 0;
  logic [63:0] wa_q[$], wd_q[$], ra_q[$];
  logic [7:0]  wm_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Bus responder: inputs updated on the falling edge, seen by the DUT on the next rise.
  initial begin
    int wcnt = 0, bcnt = 0, rcnt = 0, dcnt = 0, idx;
    logic pw_v = 0, pw_r = 0, pr_v = 0, pr_r = 0;
    logic [63:0] pw_a = '0, pw_d = '0, pr_a = '0;
    logic [7:0]  pw_m = '0;
    m64.w_ready_o = 0; m64.w_valid_o = 0; m64.rx_r_ready_o = 0;
    m64.rx_data_read_o = '0; m64.rx_data_valid = 0;
    forever begin
      @(negedge clk);
      if (r64.resp_valid) resp_cnt++;
      if ((m64.w_valid_i || m64.w_ready_i || m64.rx_r_valid_i || m64.rx_data_ready) && !r64.busy)
        busy_viol++;
      if (!rst && pw_v && !pw_r && !(m64.w_valid_i && m64.w_addr_i == pw_a &&
                                     m64.w_data_i == pw_d && m64.w_mask_i == pw_m)) hs_viol++;
      if (!rst && pr_v && !pr_r && !(m64.rx_r_valid_i && m64.rx_r_addr_i == pr_a)) hs_viol++;
      pw_v = m64.w_valid_i; pw_a = m64.w_addr_i; pw_d = m64.w_data_i; pw_m = m64.w_mask_i;
      pr_v = m64.rx_r_valid_i; pr_a = m64.rx_r_addr_i;

      if (m64.w_valid_i && wcnt >= wreq_dly) begin
        m64.w_ready_o = 1; wcnt = 0;
        wa_q.push_back(m64.w_addr_i); wd_q.push_back(m64.w_data_i); wm_q.push_back(m64.w_mask_i);
      end else begin
        m64.w_ready_o = 0; wcnt = m64.w_valid_i ? wcnt + 1 : 0;
      end
      pw_r = m64.w_ready_o;

      if (m64.w_ready_i && bcnt >= wresp_dly) begin m64.w_valid_o = 1; bcnt = 0; end
      else begin m64.w_valid_o = 0; bcnt = m64.w_ready_i ? bcnt + 1 : 0; end

      if (m64.rx_r_valid_i && rcnt >= rreq_dly) begin
        m64.rx_r_ready_o = 1; rcnt = 0; ra_q.push_back(m64.rx_r_addr_i);
      end else begin
        m64.rx_r_ready_o = 0; rcnt = m64.rx_r_valid_i ? rcnt + 1 : 0;
      end
      pr_r = m64.rx_r_ready_o;

      if (m64.rx_data_ready && dcnt >= rdat_dly) begin
        idx = ndata - beat_base;
        m64.rx_data_valid = 1;
        m64.rx_data_read_o = (idx == 0) ? beat0 : beat1;
        ndata++; dcnt = 0;
      end else begin
        m64.rx_data_valid = 0; dcnt = m64.rx_data_ready ? dcnt + 1 : 0;
      end
    end
  end

  task automatic do_req(input vec_t v, input string tag);
    int lat, nw0, nr0, rc0;
    logic [63:0] got_rd;
    logic got_err;
    @(negedge clk);
    beat0 = v.b0; beat1 = v.b1; beat_base = ndata;
    r64.req_we = v.we; r64.req_addr = v.addr; r64.req_wdata = v.wdata;
    r64.req_size = v.size; r64.req_sext = v.sext; r64.req_valid = 1;
    #1;
    nw0 = wa_q.size(); nr0 = ra_q.size(); rc0 = resp_cnt;
    chk({tag, " busy_accept"}, {r64.busy, r64.req_ready}, 2'b11);
    @(negedge clk);
    r64.req_valid = 0;
    lat = 1;
    while (!r64.resp_valid && lat < 100) begin @(negedge clk); lat++; end
    got_rd = r64.resp_rdata; got_err = r64.resp_err;
    if (!r64.resp_valid) begin
      errors++; checks++;
      $display("FAIL %s timeout: no resp_valid within %0d cycles", tag, lat);
    end
    chk({tag, " latency"}, 64'(lat), 64'(v.lat));
    chk({tag, " rdata"}, got_rd, v.rdata);
    chk({tag, " err"}, 64'(got_err), 64'(v.err));
    repeat (3) @(negedge clk);
    #1;
    chk({tag, " resp_count"}, 64'(resp_cnt - rc0), 64'd1);
    chk({tag, " rdata_hold"}, r64.resp_rdata, v.rdata);
    chk({tag, " wr_beats"}, 64'(wa_q.size() - nw0), v.we ? 64'(v.nbus) : 64'd0);
    chk({tag, " rd_beats"}, 64'(ra_q.size() - nr0), v.we ? 64'd0 : 64'(v.nbus));
    if (v.we && v.nbus >= 1 && wa_q.size() > nw0) begin
      chk({tag, " w_addr0"}, wa_q[nw0], v.a0);
      chk({tag, " w_mask0"}, 64'(wm_q[nw0]), 64'(v.m0));
      chk({tag, " w_data0"}, wd_q[nw0], v.d0);
    end
    if (v.we && v.nbus >= 2 && wa_q.size() > nw0 + 1) begin
      chk({tag, " w_addr1"}, wa_q[nw0+1], v.a1);
      chk({tag, " w_mask1"}, 64'(wm_q[nw0+1]), 64'(v.m1));
      chk({tag, " w_data1"}, wd_q[nw0+1], v.d1);
    end
    if (!v.we && v.nbus >= 1 && ra_q.size() > nr0) begin
      chk({tag, " r_addr0"}, ra_q[nr0], v.a0);
      chk({tag, " r_size"}, 64'(m64.rx_r_size_i), 64'd3);
    end
    if (!v.we && v.nbus >= 2 && ra_q.size() > nr0 + 1)
      chk({tag, " r_addr1"}, ra_q[nr0+1], v.a1);
  endtask

  initial begin
    vec_t vt[11];
    vec_t sv;
    int k, rc0;

    // we, addr, wdata, size, sext, b0, b1, rdata, err, nbus, lat, a0, m0, d0, a1, m1, d1
    vt[0]  = '{1'b1, 64'h80000004, 64'hDEADBEEF, 2'd2, 1'b0, 64'h0, 64'h0, 64'h0, 1'b0, 1, 3,
               64'h80000000, 8'hF0, 64'hDEADBEEF00000000, 64'h0, 8'h0, 64'h0};
    vt[1]  = '{1'b0, 64'h80000002, 64'h0, 2'd1, 1'b1, 64'h000000008F120000, 64'h0, 64'hFFFFFFFFFFFF8F12,
               1'b0, 1, 3, 64'h80000000, 8'h0, 64'h0, 64'h0, 8'h0, 64'h0};
    vt[2]  = '{1'b0, 64'h80000002, 64'h0, 2'd1, 1'b0, 64'h000000008F120000, 64'h0, 64'h0000000000008F12,
               1'b0, 1, 3, 64'h80000000, 8'h0, 64'h0, 64'h0, 8'h0, 64'h0};
    vt[3]  = '{1'b0, 64'h80000007, 64'h0, 2'd0, 1'b1, 64'h80FF000000000000, 64'h0, 64'hFFFFFFFFFFFFFF80,
               1'b0, 1, 3, 64'h80000000, 8'h0, 64'h0, 64'h0, 8'h0, 64'h0};
    vt[4]  = '{1'b0, 64'h80000010, 64'h0, 2'd3, 1'b1, 64'h0123456789ABCDEF, 64'h0, 64'h0123456789ABCDEF,
               1'b0, 1, 3, 64'h80000010, 8'h0, 64'h0, 64'h0, 8'h0, 64'h0};
    vt[5]  = '{1'b0, 64'h80000000, 64'h0, 2'd2, 1'b1, 64'h1234567887654321, 64'h0, 64'hFFFFFFFF87654321,
               1'b0, 1, 3, 64'h80000000, 8'h0, 64'h0, 64'h0, 8'h0, 64'h0};
    vt[6]  = '{1'b1, 64'h80000003, 64'h11223344556677A5, 2'd0, 1'b0, 64'h0, 64'h0, 64'h0, 1'b0, 1, 3,
               64'h80000000, 8'h08, 64'h44556677A5000000, 64'h0, 8'h0, 64'h0};
    vt[7]  = '{1'b1, 64'h80000008, 64'hCAFEBABE12345678, 2'd3, 1'b0, 64'h0, 64'h0, 64'h0, 1'b0, 1, 3,
               64'h80000008, 8'hFF, 64'hCAFEBABE12345678, 64'h0, 8'h0, 64'h0};
    vt[8]  = '{1'b0, 64'h80000004, 64'h0, 2'd2, 1'b1, 64'h7FFFFFFF00000000, 64'h0, 64'h000000007FFFFFFF,
               1'b0, 1, 3, 64'h80000000, 8'h0, 64'h0, 64'h0, 8'h0, 64'h0};
`ifdef LSU_MISALIGN_SPLIT_EN
    vt[9]  = '{1'b0, 64'h80000006, 64'h0, 2'd2, 1'b0, 64'hBBAA000000000000, 64'h000000000000DDCC,
               64'h00000000DDCCBBAA, 1'b0, 2, 5, 64'h80000000, 8'h0, 64'h0, 64'h80000008, 8'h0, 64'h0};
    vt[10] = '{1'b1, 64'h80000005, 64'h11223344, 2'd2, 1'b0, 64'h0, 64'h0, 64'h0, 1'b0, 2, 5,
               64'h80000000, 8'hE0, 64'h2233440000000000, 64'h80000008, 8'h01, 64'h0000000000000011};
`else
    vt[9]  = '{1'b0, 64'h80000006, 64'h0, 2'd2, 1'b0, 64'hBBAA000000000000, 64'h000000000000DDCC,
               64'h0, 1'b1, 0, 1, 64'h0, 8'h0, 64'h0, 64'h0, 8'h0, 64'h0};
    vt[10] = '{1'b1, 64'h80000005, 64'h11223344, 2'd2, 1'b0, 64'h0, 64'h0, 64'h0, 1'b1, 0, 1,
               64'h0, 8'h0, 64'h0, 64'h0, 8'h0, 64'h0};
`endif

    r64.req_valid = 0; r64.req_we = 0; r64.req_addr = '0; r64.req_wdata = '0;
    r64.req_size = '0; r64.req_sext = 0;
    r32.req_valid = 0; r32.req_we = 0; r32.req_addr = '0; r32.req_wdata = '0;
    r32.req_size = '0; r32.req_sext = 0;
    m32.w_ready_o = 0; m32.w_valid_o = 0; m32.rx_r_ready_o = 0;
    m32.rx_data_read_o = '0; m32.rx_data_valid = 0;

    repeat (3) @(negedge clk);
    chk("rst req_ready", 64'(r64.req_ready), 64'd1);
    chk("rst outputs", {r64.resp_valid, r64.resp_err, m64.w_valid_i, m64.w_ready_i,
                        m64.rx_r_valid_i, m64.rx_data_ready, r64.busy}, 64'd0);
    chk("rst mask/size", {m64.w_mask_i, m64.rx_r_size_i}, 64'd0);
    rst = 0;

    for (int i = 0; i < 11; i++) do_req(vt[i], $sformatf("vec%0d", i));

    // Stalled store: ready held off 5 cycles, write response delayed 3.
    wreq_dly = 5; wresp_dly = 3;
    sv = vt[0]; sv.lat = 11;
    do_req(sv, "stall");
    wreq_dly = 0; wresp_dly = 0;
    chk("stall handshake_stable", 64'(hs_viol), 64'd0);
    chk("stall busy_held", 64'(busy_viol), 64'd0);

    // Reset while waiting for read data.
    rdat_dly = 40;
    @(negedge clk);
    beat0 = 64'h1111111111111111; beat_base = ndata;
    r64.req_we = 0; r64.req_addr = 64'h80000000; r64.req_size = 2'd3; r64.req_sext = 0;
    r64.req_valid = 1;
    @(negedge clk);
    r64.req_valid = 0;
    k = 0;
    while (!m64.rx_data_ready && k < 20) begin @(negedge clk); k++; end
    chk("rst_mid reached_rdata", 64'(m64.rx_data_ready), 64'd1);
    #1 rc0 = resp_cnt;
    rst = 1;
    #1;
    chk("rst_mid req_ready", 64'(r64.req_ready), 64'd1);
    chk("rst_mid outputs", {r64.resp_valid, m64.rx_data_ready, m64.rx_r_valid_i, m64.w_valid_i,
                            m64.w_ready_i, r64.busy}, 64'd0);
    chk("rst_mid rdata_cleared", r64.resp_rdata, 64'd0);
    repeat (2) @(negedge clk);
    rst = 0; rdat_dly = 0;
    repeat (4) @(negedge clk);
    #1 chk("rst_mid no_resp", 64'(resp_cnt - rc0), 64'd0);
    do_req(vt[1], "post_rst");

    // 32-bit instance: 8-byte access is illegal, answered on T1 without bus traffic.
    @(negedge clk);
    r32.req_we = 0; r32.req_addr = 32'h00001000; r32.req_size = 2'd3; r32.req_valid = 1;
    #1 chk("x32 busy_accept", 64'(r32.busy), 64'd1);
    @(negedge clk);
    r32.req_valid = 0;
    chk("x32 resp_T1", {r32.resp_valid, r32.resp_err}, 64'b11);
    chk("x32 no_bus_T1", {m32.w_valid_i, m32.rx_r_valid_i}, 64'd0);
    @(negedge clk);
    chk("x32 resp_single", 64'(r32.resp_valid), 64'd0);
    chk("x32 idle_again", {r32.req_ready, m32.w_valid_i, m32.rx_r_valid_i}, 64'b100);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/lsu_axi_bridge.md
Name: lsu_axi_bridge

Overview:
Parametrised load/store unit between the MEM pipeline stage and the AXI-style data-memory port.
- Accepts one request at a time: load or store, 1/2/4/8 bytes, any byte offset.
- Generates aligned bus beats with correct byte lanes and strobes.
- Returns sign- or zero-extended load data.
- Holds `busy` high so the pipeline stalls while a bus transaction is outstanding.

Parameters:
- XLEN, 64, data/bus width in bits (32 or 64); BYTES = XLEN/8.
- ADDR_W, 64, address width.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- req_valid  in  1  request from MEM stage
- req_ready  out  1  high only in IDLE
- req_we  in  1  1=store, 0=load
- req_addr  in  ADDR_W  byte address
- req_wdata  in  XLEN  store data, right-justified
- req_size  in  2  log2 byte count (0..3)
- req_sext  in  1  sign-extend load
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  XLEN  extended load data (0 for stores)
- resp_err  out  1  with resp_valid: illegal/unsupported access
- busy  out  1  stall request to pipeline
- w_valid_i  out  1  write request valid
- w_ready_o  in  1  write request accepted
- w_addr_i  out  ADDR_W  BYTES-aligned write address
- w_data_i  out  XLEN  lane-shifted write data
- w_mask_i  out  BYTES  byte strobes
- w_valid_o  in  1  write response valid
- w_ready_i  out  1  write response ready
- rx_r_valid_i  out  1  read request valid
- rx_r_ready_o  in  1  read request accepted
- rx_r_addr_i  out  ADDR_W  BYTES-aligned read address
- rx_r_size_i  out  8  log2(BYTES)
- rx_data_read_o  in  XLEN  read data
- rx_data_valid  in  1  read data valid
- rx_data_ready  out  1  read data ready

Behaviour:
- Reset: all outputs 0 except req_ready=1; state=IDLE.
  - Reset mid-operation aborts the access.
  - No response is issued; the bus side is reset with it.
- States: IDLE, WREQ, WRESP, RREQ, RDATA, RESP.
- IDLE, on accept (req_valid && req_ready):
  - Latch the request.
  - Compute off = addr mod BYTES and n = 1<<size.
  - Compute mask = ((1<<n)-1)<<off and data = wdata<<(8*off).
  - Compute base = addr with low log2(BYTES) bits cleared.
- Illegal size (size=3 when XLEN=32) -> RESP with resp_err=1, no bus traffic.
- Misaligned access (off+n > BYTES) is handled per the Optional Feature section.
- Otherwise go to WREQ (store) or RREQ (load).
- WREQ: w_valid_i=1 with addr/data/mask stable until w_ready_o; then -> WRESP.
- WRESP: w_ready_i=1; on w_valid_o -> RESP, or to the second beat when splitting.
- RREQ: rx_r_valid_i=1, address stable until rx_r_ready_o; then -> RDATA.
- RDATA: rx_data_ready=1; on rx_data_valid, capture the beat; -> RESP or second beat.
- Load extraction: (beat >> 8*off) truncated to n bytes, then sign-extended if req_sext, else zero-extended; n=BYTES passes through unchanged.
- RESP: resp_valid=1 for exactly one cycle, then -> IDLE.
- busy = (state != IDLE) || (req_valid && req_ready); it is combinational so the pipeline stalls in the accept cycle.
- Latency with zero-wait bus: accept T0, request T1, resp_valid T3.
- Handshakes:
  - valid never drops before ready.
  - ready and valid both high in one cycle completes the transfer that cycle.
- resp_rdata holds its value until the next response.

Optional Feature:
LSU_MISALIGN_SPLIT_EN:
- Defined: a misaligned access becomes two beats.
  - Beat 1 at base: bytes off..BYTES-1, mask = low part of the shifted mask.
  - Beat 2 at base+BYTES: remaining k = off+n-BYTES bytes, mask (1<<k)-1, data = wdata>>(8*(BYTES-off)).
- Loads from split beats:
  - Concatenate beat2[8k-1:0] above beat1>>(8*off), then extend.
  - One resp_valid after beat 2; resp_err=0.
- Undefined: a misaligned access goes directly to RESP with resp_err=1 and no bus traffic.

Test Plan:
- XLEN=64, store addr=0x80000004 size=2 wdata=0xDEADBEEF -> w_addr_i=0x80000000, w_mask_i=0xF0, w_data_i=0xDEADBEEF00000000; resp_valid once, err=0.
- Load addr=0x80000002 size=1 sext=1, bus returns 0x00000000_8F120000 -> resp_rdata=0xFFFFFFFFFFFF8F12; with sext=0 -> 0x0000000000008F12.
- Bus stalls: w_ready_o low 5 cycles, w_valid_o delayed 3 -> w_valid_i and addr stable throughout, busy high, exactly one resp_valid.
- Misaligned load addr=0x80000006 size=2, beats 0xBBAA0000_00000000 then 0x00000000_0000DDCC:
  - With LSU_MISALIGN_SPLIT_EN: two reads at 0x80000000 and 0x80000008; resp_rdata=0xDDCCBBAA.
  - Without: resp_err=1 and no rx_r_valid_i.
- Assert rst during RDATA -> all outputs 0 immediately, req_ready=1, no resp_valid; next request completes normally.
- XLEN=32, size=3 request -> resp_err=1 on T1, no bus activity.
